// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op, state and ALU control encodings shared by the sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4,
    OP_INC = 3'd5,
    OP_DEC = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Field order matches the external ALU control word: zl, il, zr, ir, opcode, invert_result.
  typedef struct packed {
    logic zl;
    logic il;
    logic zr;
    logic ir;
    logic opcode;
    logic ir_res;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_NONE = 6'b000000;
  localparam alu_ctrl_t CTRL_ADD  = 6'b000010;
  localparam alu_ctrl_t CTRL_SUB  = 6'b010011;
  localparam alu_ctrl_t CTRL_AND  = 6'b000000;
  localparam alu_ctrl_t CTRL_OR   = 6'b010101;
  localparam alu_ctrl_t CTRL_NOT  = 6'b001101;
  localparam alu_ctrl_t CTRL_INC  = 6'b011111;
  localparam alu_ctrl_t CTRL_DEC  = 6'b001110;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational op to external-ALU control word decode
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  output alu_ctrl_t  ctrl_o
);

  // MUL has no single-step encoding; the sequencer steers the ALU itself for it.
  always_comb begin
    ctrl_o = CTRL_NONE;
    case (op_e'(op_i))
      OP_ADD:  ctrl_o = CTRL_ADD;
      OP_SUB:  ctrl_o = CTRL_SUB;
      OP_AND:  ctrl_o = CTRL_AND;
      OP_OR:   ctrl_o = CTRL_OR;
      OP_NOT:  ctrl_o = CTRL_NOT;
      OP_INC:  ctrl_o = CTRL_INC;
      OP_DEC:  ctrl_o = CTRL_DEC;
      default: ctrl_o = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving an external ALU
// ALU_SEQ_MUL_EN enables the WIDTH-cycle shift-add multiply; otherwise op 7 returns an error.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic             alu_zero_lhs,
  output logic             alu_invert_lhs,
  output logic             alu_zero_rhs,
  output logic             alu_invert_rhs,
  output logic             alu_opcode,
  output logic             alu_invert_result,
  output logic [WIDTH-1:0] alu_lhs,
  output logic [WIDTH-1:0] alu_rhs,
  input  logic [WIDTH-1:0] alu_result
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             neg_q;
  logic             err_q;

  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             neg_d;

  alu_ctrl_t dec_ctrl;
  alu_ctrl_t ctrl;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
`endif

  alu_seq_decode u_decode (
    .op_i   (op_q),
    .ctrl_o (dec_ctrl)
  );

  assign result_d = alu_result;
  assign zero_d   = (alu_result == '0);
  assign neg_d    = alu_result[WIDTH-1];

  always_comb begin
    ctrl    = CTRL_NONE;
    alu_lhs = '0;
    alu_rhs = '0;
    case (state_q)
      ST_EXEC: begin
        ctrl    = dec_ctrl;
        alu_lhs = a_q;
        alu_rhs = b_q;
      end
`ifdef ALU_SEQ_MUL_EN
      // One shift-add step: add the shifted multiplicand only when the current multiplier bit is set.
      ST_MUL: begin
        ctrl    = CTRL_ADD;
        ctrl.zr = ~mplier_q[0];
        alu_lhs = acc_q;
        alu_rhs = mcand_q;
      end
`endif
      default: begin
        ctrl    = CTRL_NONE;
        alu_lhs = '0;
        alu_rhs = '0;
      end
    endcase
  end

  assign alu_zero_lhs      = ctrl.zl;
  assign alu_invert_lhs    = ctrl.il;
  assign alu_zero_rhs      = ctrl.zr;
  assign alu_invert_rhs    = ctrl.ir;
  assign alu_opcode        = ctrl.opcode;
  assign alu_invert_result = ctrl.ir_res;

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_neg    = neg_q;
  assign rsp_err    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= op_e'(req_op);
            a_q  <= req_a;
            b_q  <= req_b;
            if (is_mul(req_op)) begin
`ifdef ALU_SEQ_MUL_EN
              acc_q    <= '0;
              mcand_q  <= req_a;
              mplier_q <= req_b;
              cnt_q    <= '0;
              state_q  <= ST_MUL;
`else
              result_q <= '0;
              zero_q   <= 1'b1;
              neg_q    <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= ST_RESP;
`endif
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          result_q <= result_d;
          zero_q   <= zero_d;
          neg_q    <= neg_d;
          err_q    <= 1'b0;
          state_q  <= ST_RESP;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          acc_q    <= alu_result;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // The final step's sum goes straight to the response so RESP starts the next cycle.
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            err_q    <= 1'b0;
            state_q  <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  localparam int W = 16;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_neg, rsp_err;
  logic         alu_zero_lhs, alu_invert_lhs, alu_zero_rhs, alu_invert_rhs;
  logic         alu_opcode, alu_invert_result;
  logic [W-1:0] alu_lhs, alu_rhs, alu_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_a             (req_a),
    .req_b             (req_b),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_result        (rsp_result),
    .rsp_zero          (rsp_zero),
    .rsp_neg           (rsp_neg),
    .rsp_err           (rsp_err),
    .alu_zero_lhs      (alu_zero_lhs),
    .alu_invert_lhs    (alu_invert_lhs),
    .alu_zero_rhs      (alu_zero_rhs),
    .alu_invert_rhs    (alu_invert_rhs),
    .alu_opcode        (alu_opcode),
    .alu_invert_result (alu_invert_result),
    .alu_lhs           (alu_lhs),
    .alu_rhs           (alu_rhs),
    .alu_result        (alu_result)
  );

  // External ALU: zero/invert each input, add or AND, optionally invert the output.
  logic [W-1:0] ax, ay, ao;
  always_comb begin
    ax = alu_zero_lhs ? '0 : alu_lhs;
    ax = alu_invert_lhs ? ~ax : ax;
    ay = alu_zero_rhs ? '0 : alu_rhs;
    ay = alu_invert_rhs ? ~ay : ay;
    ao = alu_opcode ? (ax + ay) : (ax & ay);
    alu_result = alu_invert_result ? ~ao : ao;
  end

  function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    int unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ~ua;
      3'd5: r = ua + 1;
      3'd6: r = ua - 1;
      default: r = MUL_EN ? ua * ub : 0;
    endcase
    return W'(r % 65536);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; the next transaction may start immediately.
  task automatic txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int bp);
    logic [W-1:0] er;
    logic         ez, en, ee;
    int           el, k, lat;
    bit           done;
    er = model_result(op, a, b);
    ez = (er == 0);
    en = er[W-1];
    ee = (op == 3'd7) && !MUL_EN;
    el = (op != 3'd7) ? 2 : (MUL_EN ? W + 1 : 1);

    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    check("alu_ctrl_idle", {26'd0, alu_zero_lhs, alu_invert_lhs, alu_zero_rhs, alu_invert_rhs,
                            alu_opcode, alu_invert_result, alu_lhs, alu_rhs}, 64'd0);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = W'($urandom);
    req_b = W'($urandom);

    done = 0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (rsp_valid) done = 1;
    end
    lat = done ? k : -1;
    check("latency", 64'(lat), 64'(el));
    check("result", {48'd0, rsp_result}, {48'd0, er});
    check("flags", {61'd0, rsp_zero, rsp_neg, rsp_err}, {61'd0, ez, en, ee});

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_hold", {43'd0, rsp_valid, req_ready, rsp_result, rsp_zero, rsp_neg, rsp_err},
            {43'd0, 1'b1, 1'b0, er, ez, en, ee});
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("after_handshake", {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("reset_ready", {63'd0, req_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {44'd0, req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_err},
          {44'd0, 1'b1, 1'b0, 16'd0, 3'd0});

    txn(3'd0, 16'd20, 16'd5, 0);
    txn(3'd1, 16'd20, 16'd5, 0);
    txn(3'd1, 16'd5, 16'd20, 1);
    txn(3'd5, 16'hFFFF, 16'h1234, 0);
    txn(3'd3, 16'h00F0, 16'h0F00, 0);
    txn(3'd4, 16'h00FF, 16'h0000, 0);
    txn(3'd2, 16'hF0F0, 16'h3C3C, 0);
    txn(3'd6, 16'h0000, 16'h0000, 0);
    txn(3'd0, 16'hFFFF, 16'h0001, 5);
    txn(3'd7, 16'd300, 16'd300, 0);
    txn(3'd7, 16'd0, 16'd7, 0);
    txn(3'd7, 16'd3, 16'd4, 2);
    txn(3'd0, 16'd3, 16'd4, 0);

    for (int n = 0; n < 24; n++) begin
      txn(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // Abort mid-operation: cycle 8 of MUL when enabled, otherwise the EXEC cycle.
    req_valid = 1'b1;
    req_op = MUL_EN ? 3'd7 : 3'd0;
    req_a = 16'd9;
    req_b = 16'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (MUL_EN ? 8 : 1) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", {44'd0, req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_err},
          {44'd0, 1'b1, 1'b0, 16'd0, 3'd0});
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("no_rsp_after_abort", {63'd0, seen}, 64'd0);
    txn(3'd0, 16'd1, 16'd1, 0);

    // Reset beats a simultaneous request.
    req_valid = 1'b1;
    req_op = 3'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_over_req", {62'd0, req_ready, rsp_valid}, 64'd2);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("no_rsp_after_reset_req", {63'd0, seen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
